uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority-vote sampling and per-frame error pulses
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVS        = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);

    localparam int EW = $clog2(OVS);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] E_LO   = EW'(OVS / 2 - 1);
    localparam logic [EW-1:0] E_MID  = EW'(OVS / 2);
    localparam logic [EW-1:0] E_HI   = EW'(OVS / 2 + 1);
    localparam logic [EW-1:0] E_LAST = EW'(OVS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [EW-1:0]           edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    sync_meta_q, sync_meta_d;
    logic                    rxs_q, rxs_d;
    logic                    samp_lo_q, samp_lo_d;
    logic                    samp_mid_q, samp_mid_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    par_bad_q, par_bad_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q, par_err_d;
    logic                    stp_err_q, stp_err_d;
    logic                    maj;
    logic                    edge_wrap;
    logic                    eval;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            sync_meta_q  <= 1'b1;
            rxs_q        <= 1'b1;
            samp_lo_q    <= 1'b1;
            samp_mid_q   <= 1'b1;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            sync_meta_q  <= sync_meta_d;
            rxs_q        <= rxs_d;
            samp_lo_q    <= samp_lo_d;
            samp_mid_q   <= samp_mid_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    // The third vote is the live synchronized sample, so every decision lands on edge E_HI.
    assign maj       = (samp_lo_q & samp_mid_q) | (samp_lo_q & rxs_q) | (samp_mid_q & rxs_q);
    assign edge_wrap = (edge_cnt_q == E_LAST);
    assign eval      = (edge_cnt_q == E_HI);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_wrap ? '0 : edge_cnt_q + EW'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        sync_meta_d  = RX_IN;
        rxs_d        = sync_meta_q;
        samp_lo_d    = (edge_cnt_q == E_LO)  ? rxs_q : samp_lo_q;
        samp_mid_d   = (edge_cnt_q == E_MID) ? rxs_q : samp_mid_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (eval) begin
                    if (maj) begin
                        state_d    = S_IDLE;
                        edge_cnt_d = '0;
                    end else begin
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                        par_bad_d = 1'b0;
                    end
                end
                if (edge_wrap) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (eval) begin
                    shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                end
                if (edge_wrap) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == B_LAST) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (eval) begin
                    par_bad_d = maj ^ (^shift_q) ^ par_typ_q;
                end
                if (edge_wrap) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave mid-stop-bit so a start edge half a bit later is not missed.
                if (eval) begin
                    stp_err_d  = ~maj;
                    par_err_d  = par_bad_q;
                    state_d    = S_IDLE;
                    edge_cnt_d = '0;
                    if (maj && !par_bad_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (OVS=8, DATA_WIDTH=8)
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       BUSY;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;

    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cnt = 0;
    int dv_last_cyc = 0, dv_prev_cyc = 0, pe_cyc = 0, se_cyc = 0, se_prev_cyc = 0;
    logic [7:0] dv_last_data = 8'h00, dv_prev_data = 8'h00;
    int dv0, pe0, se0, busy0;

    uart_rx #(.DATA_WIDTH(8), .OVS(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DATA_VALID) begin
            dv_cnt       <= dv_cnt + 1;
            dv_prev_cyc  <= dv_last_cyc;
            dv_last_cyc  <= cyc;
            dv_prev_data <= dv_last_data;
            dv_last_data <= P_DATA;
        end
        if (PAR_ERR) begin
            pe_cnt <= pe_cnt + 1;
            pe_cyc <= cyc;
        end
        if (STP_ERR) begin
            se_cnt      <= se_cnt + 1;
            se_prev_cyc <= se_cyc;
            se_cyc      <= cyc;
        end
        if (BUSY) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic b);
        @(posedge CLK);
        #1 RX_IN = b;
    endtask

    task automatic idle(input int n);
        repeat (n) line(1'b1);
    endtask

    task automatic snap();
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; busy0 = busy_cnt;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic stop_bit, input logic inv);
        line(1'b0);
        start_cyc = cyc;
        repeat (7) line(1'b0);
        for (int j = 0; j < 8; j++)
            for (int o = 0; o < 8; o++)
                line((inv && o == 5) ? ~d[j] : d[j]);
        if (has_par) repeat (8) line(par_bit);
        repeat (8) line(stop_bit);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_pdata", P_DATA, 8'h00);
        chk("rst_dv", DATA_VALID, 1'b0);
        chk("rst_pe", PAR_ERR, 1'b0);
        chk("rst_se", STP_ERR, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        RST = 1'b0;
        idle(5);

        // 0xD8, no parity: pulse 78 cycles after t0, t0 = line edge + 3
        snap();
        send_frame(8'hD8, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        chk("d8_data", P_DATA, 8'hD8);
        chk("d8_dvcnt", dv_cnt - dv0, 1);
        chk("d8_cyc", dv_last_cyc - start_cyc, 81);
        chk("d8_errs", (pe_cnt - pe0) + (se_cnt - se0), 0);
        chk("d8_busy", BUSY, 1'b0);

        // odd parity 0xDF (seven ones) -> parity bit 0, pulse at t0+86
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send_frame(8'hDF, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(12);
        chk("df_data", P_DATA, 8'hDF);
        chk("df_dvcnt", dv_cnt - dv0, 1);
        chk("df_cyc", dv_last_cyc - start_cyc, 89);
        chk("df_pe", pe_cnt - pe0, 0);

        // even parity 0xAC (four ones) -> parity bit 0
        PAR_TYP = 1'b0;
        snap();
        send_frame(8'hAC, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(12);
        chk("ac_data", P_DATA, 8'hAC);
        chk("ac_dvcnt", dv_cnt - dv0, 1);

        // same word, parity bit forced wrong
        snap();
        send_frame(8'hAC, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(12);
        chk("pe_cnt", pe_cnt - pe0, 1);
        chk("pe_cyc", pe_cyc - start_cyc, 89);
        chk("pe_dv", dv_cnt - dv0, 0);
        chk("pe_se", se_cnt - se0, 0);
        chk("pe_hold", P_DATA, 8'hAC);

        // stop bit forced low
        PAR_EN = 1'b0;
        snap();
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        chk("se_cnt", se_cnt - se0, 1);
        chk("se_cyc", se_cyc - start_cyc, 81);
        chk("se_dv", dv_cnt - dv0, 0);
        chk("se_hold", P_DATA, 8'hAC);
        chk("se_busy", BUSY, 1'b0);

        // two-cycle start glitch: BUSY for the 6 START cycles only
        snap();
        line(1'b0);
        line(1'b0);
        idle(20);
        chk("gl_busy", busy_cnt - busy0, 6);
        chk("gl_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        chk("gl_55", P_DATA, 8'h55);
        chk("gl_dvcnt", dv_cnt - dv0, 1);

        // back-to-back frames
        snap();
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        chk("b2b_dvcnt", dv_cnt - dv0, 2);
        chk("b2b_gap", dv_last_cyc - dv_prev_cyc, 80);
        chk("b2b_first", dv_prev_data, 8'h0F);
        chk("b2b_second", P_DATA, 8'hF0);

        // one-cycle inversion on the middle vote of every data bit
        snap();
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(12);
        chk("inv_data", P_DATA, 8'h96);
        chk("inv_dvcnt", dv_cnt - dv0, 1);

        // reset pulse during DATA bit 4 of 0x3C
        snap();
        line(1'b0);
        repeat (7) line(1'b0);
        for (int j = 0; j < 4; j++) repeat (8) line(j >= 2);
        repeat (4) line(1'b1);
        @(posedge CLK);
        #1 RST = 1'b1; RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        chk("ra_busy", BUSY, 1'b0);
        chk("ra_pdata", P_DATA, 8'h00);
        chk("ra_dv", DATA_VALID, 1'b0);
        RST = 1'b0;
        idle(100);
        chk("ra_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        chk("ra_a5", P_DATA, 8'hA5);
        chk("ra_dvcnt", dv_cnt - dv0, 1);

        // break: line low long enough for exactly two frames (79-cycle period)
        snap();
        line(1'b0);
        start_cyc = cyc;
        repeat (157) line(1'b0);
        idle(30);
        chk("brk_se", se_cnt - se0, 2);
        chk("brk_first", se_prev_cyc - start_cyc, 81);
        chk("brk_period", se_cyc - se_prev_cyc, 79);
        chk("brk_dv", dv_cnt - dv0, 0);
        chk("brk_hold", P_DATA, 8'hA5);
        chk("brk_busy", BUSY, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
